ras_ckpt: RTL

//  Parametrised return address stack (RAS) for the fetch predictor; successor to the fixed 16-entry RAS.

---
 rtl/ras_ckpt_pkg.sv | 21 ++
 rtl/ras_ckpt.sv | 104 ++++++++++
 2 files changed

// File: rtl/ras_ckpt_pkg.sv
// Shared types and constants for the fetch-predictor return address stack.
// The default depth and PC width here match ras_ckpt's parameter defaults.
package ras_ckpt_pkg;

  localparam int DEF_RAS_ENTRIES  = 16;
  localparam int DEF_LOG_ENTRIES  = $clog2(DEF_RAS_ENTRIES);
  localparam int DEF_PC_WIDTH     = 38;

  typedef logic [DEF_PC_WIDTH-1:0]    PC38_t;
  typedef logic [DEF_LOG_ENTRIES-1:0] RAS_idx_t;
  typedef logic [DEF_LOG_ENTRIES:0]   RAS_cnt_t;

  // Snapshot held in the checkpoint array; restored through restore_sp/restore_cnt.
  typedef struct packed {
    RAS_idx_t sp;
    RAS_cnt_t cnt;
  } RAS_ckpt_t;

  localparam PC38_t INIT_PC38 = '0;

endpackage

// File: rtl/ras_ckpt.sv
// Circular return address stack with single-cycle {sp, cnt} restore.
// Optional macro RAS_RESTORE_TOP_EN adds restore_top_pc38 to repair the top entry on restore.
module ras_ckpt
  import ras_ckpt_pkg::*;
#(
  parameter int RAS_ENTRIES = 16,
  parameter int PC_WIDTH    = 38
) (
  input  logic                            CLK,
  input  logic                            nRST,
  input  logic                            push_valid,
  input  logic [PC_WIDTH-1:0]             push_pc38,
  input  logic                            pop_valid,
  output logic                            ret_valid,
  output logic [PC_WIDTH-1:0]             ret_pc38,
  output logic [$clog2(RAS_ENTRIES)-1:0]  ras_sp,
  output logic [$clog2(RAS_ENTRIES):0]    ras_cnt,
  input  logic                            restore_valid,
  input  logic [$clog2(RAS_ENTRIES)-1:0]  restore_sp,
  input  logic [$clog2(RAS_ENTRIES):0]    restore_cnt,
`ifdef RAS_RESTORE_TOP_EN
  input  logic [PC_WIDTH-1:0]             restore_top_pc38,
`endif
  output logic                            overflow,
  output logic                            underflow
);

  localparam int LOG_W = $clog2(RAS_ENTRIES);
  localparam int CNT_W = LOG_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(RAS_ENTRIES);

  logic [PC_WIDTH-1:0] stack [RAS_ENTRIES];
  logic [LOG_W-1:0]    sp, sp_nx;
  logic [CNT_W-1:0]    cnt, cnt_nx;
  logic                wr_en;
  logic [LOG_W-1:0]    wr_idx;
  logic [PC_WIDTH-1:0] wr_data;
  logic                ovf_nx, unf_nx;

  always_comb begin
    sp_nx   = sp;
    cnt_nx  = cnt;
    wr_en   = 1'b0;
    wr_idx  = sp + LOG_W'(1);
    wr_data = push_pc38;
    ovf_nx  = 1'b0;
    unf_nx  = 1'b0;
    if (restore_valid) begin
      sp_nx  = restore_sp;
      cnt_nx = restore_cnt;
`ifdef RAS_RESTORE_TOP_EN
      if (restore_cnt != '0) begin
        wr_en   = 1'b1;
        wr_idx  = restore_sp;
        wr_data = restore_top_pc38;
      end
`endif
    end else if (push_valid && pop_valid) begin
      // RET_L: replace the top in place; on an empty stack it degrades to a push.
      wr_en = 1'b1;
      if (cnt != '0) begin
        wr_idx = sp;
      end else begin
        sp_nx  = sp + LOG_W'(1);
        cnt_nx = CNT_W'(1);
        unf_nx = 1'b1;
      end
    end else if (push_valid) begin
      wr_en = 1'b1;
      sp_nx = sp + LOG_W'(1);
      if (cnt < FULL) cnt_nx = cnt + CNT_W'(1);
      else            ovf_nx = 1'b1;
    end else if (pop_valid) begin
      if (cnt != '0) begin
        sp_nx  = sp - LOG_W'(1);
        cnt_nx = cnt - CNT_W'(1);
      end else begin
        unf_nx = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      sp        <= '0;
      cnt       <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      for (int i = 0; i < RAS_ENTRIES; i++) stack[i] <= PC_WIDTH'(INIT_PC38);
    end else begin
      sp        <= sp_nx;
      cnt       <= cnt_nx;
      overflow  <= ovf_nx;
      underflow <= unf_nx;
      if (wr_en) stack[wr_idx] <= wr_data;
    end
  end

  assign ret_valid = (cnt != '0);
  assign ret_pc38  = stack[sp];
  assign ras_sp    = sp;
  assign ras_cnt   = cnt;

endmodule
